// File: rtl/lane_light_sequencer_pkg.sv
// Shared types for the intersection lamp sequencer: mode, light and phase encodings, lane indices.
// Latency: n/a (types only); backpressure: n/a.
package lane_light_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_NIGHT = 2'b00,
        MODE_DAY   = 2'b01,
        MODE_PED   = 2'b10,
        MODE_EMG   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        LT_RED    = 2'b00,
        LT_YELLOW = 2'b01,
        LT_GREEN  = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10
    } phase_t;

    localparam int NUM_LANES = 8;
    localparam int LANE_N1   = 7;
    localparam int LANE_N2   = 6;
    localparam int LANE_E1   = 5;
    localparam int LANE_E2   = 4;
    localparam int LANE_S1   = 3;
    localparam int LANE_S2   = 2;
    localparam int LANE_W1   = 1;
    localparam int LANE_W2   = 0;

    // Pedestrian and emergency modes must never see a lane go green.
    function automatic logic mode_allows_green(input mode_t m);
        return (m == MODE_NIGHT) || (m == MODE_DAY);
    endfunction

endpackage

// File: rtl/lane_light_sequencer_phase_timer.sv
// Saturating down-counter timing each light phase; load wins over decrement.
// Latency: count updates one edge after load/dec; backpressure: none.
module phase_timer #(
    parameter int             TW      = 8,
    parameter logic [TW-1:0]  RST_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [TW-1:0] o_count,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/lane_light_sequencer.sv
// Turns the DayTime lane grant into safe lamp colours with min green, yellow and all-red clearance.
// Latency: first green ALLRED_CYC edges after reset; backpressure: none, lane_req sampled only at grant.
module lane_light_sequencer
    import lane_light_sequencer_pkg::*;
#(
    parameter int GREEN_MIN  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int TW         = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_lane_req,
    input  logic [1:0]  i_mode,
    output logic [15:0] o_lights,
    output logic [1:0]  o_phase,
    output logic        o_grant_ack
);

    localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_CYC - 1);

    phase_t        r_state;
    logic [7:0]    r_active;
    logic          r_grant_ack;

    phase_t        w_state_nxt;
    mode_t         w_mode;
    logic          w_grant;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic [TW-1:0] w_timer;
    logic          w_timer_zero;
    logic          w_enter_all_red;

    assign w_mode = mode_t'(i_mode);

    phase_timer #(
        .TW      (TW),
        .RST_VAL (ALLRED_LD)
    ) u_phase_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (1'b1),
        .o_count    (w_timer),
        .o_zero     (w_timer_zero)
    );

    // State register, plus the lane set and ack pulse that change with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= PH_ALL_RED;
            r_active    <= '0;
            r_grant_ack <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_ack <= w_grant;
            if (w_grant) begin
                r_active <= i_lane_req;
            end else if (w_enter_all_red) begin
                r_active <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant         = 1'b0;
        w_load          = 1'b0;
        w_load_val      = '0;
        w_enter_all_red = 1'b0;
        case (r_state)
            PH_ALL_RED: begin
                if (w_timer_zero && mode_allows_green(w_mode) && (i_lane_req != 8'h00)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = PH_GREEN;
                    w_load      = 1'b1;
                    w_load_val  = GREEN_LD;
                end
            end
            PH_GREEN: begin
                // Ped/emergency waives the remaining minimum green.
                if (!mode_allows_green(w_mode) || (w_timer_zero && (i_lane_req != r_active))) begin
                    w_state_nxt = PH_YELLOW;
                    w_load      = 1'b1;
                    w_load_val  = YELLOW_LD;
                end
            end
            PH_YELLOW: begin
                if (w_timer_zero) begin
                    w_state_nxt     = PH_ALL_RED;
                    w_load          = 1'b1;
                    w_load_val      = ALLRED_LD;
                    w_enter_all_red = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = PH_ALL_RED;
                w_load          = 1'b1;
                w_load_val      = ALLRED_LD;
                w_enter_all_red = 1'b1;
            end
        endcase
    end

    // Moore decode: only lanes in the latched set ever leave red.
    always_comb begin
        o_lights    = '0;
        o_phase     = r_state;
        o_grant_ack = r_grant_ack;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_active[i]) begin
                case (r_state)
                    PH_GREEN:  o_lights[2*i +: 2] = LT_GREEN;
                    PH_YELLOW: o_lights[2*i +: 2] = LT_YELLOW;
                    default:   o_lights[2*i +: 2] = LT_RED;
                endcase
            end
        end
    end

endmodule
